// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp patterns for the traffic signal controllers.
// Latency: none (type and constant definitions only).
// Backpressure: none.
//
// Contents:
//   phase_e    - controller phase, also driven out on the phase output
//   LED_GREEN  - {G,Y,R} lamp pattern for a green approach
//   LED_YELLOW - {G,Y,R} lamp pattern for a yellow approach
//   LED_RED    - {G,Y,R} lamp pattern for a red approach
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } phase_e;

    localparam logic [2:0] LED_GREEN  = 3'b100;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b001;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between sensor conditioning / timebase and the phase controller.
// Latency: none (wires only).
// Backpressure: none; tick and sensor are sampled every clk, lamps are driven every clk.
//
// Signals:
//   tick       - one-cycle timebase strobe
//   sensor     - per-approach vehicle request
//   led        - per-approach {G,Y,R} lamps, approach i at led[3*i +: 3]
//   green_id   - approach owning the current phase
//   phase      - current controller phase
//   preempt    - emergency preemption request   (only with TRAFFIC_PREEMPT_EN)
//   preempt_id - approach to preempt to         (only with TRAFFIC_PREEMPT_EN)
// Modports: master = sensor/timebase side, slave = the phase controller.
interface traffic_phase_ctrl_if #(
    parameter int N_APPROACH = 4
);
    import traffic_pkg::*;

    localparam int ID_W = $clog2(N_APPROACH);

    logic                    tick;
    logic [N_APPROACH-1:0]   sensor;
    logic [3*N_APPROACH-1:0] led;
    logic [ID_W-1:0]         green_id;
    phase_e                  phase;

`ifdef TRAFFIC_PREEMPT_EN
    logic                    preempt;
    logic [ID_W-1:0]         preempt_id;

    modport master (
        output tick, sensor, preempt, preempt_id,
        input  led, green_id, phase
    );

    modport slave (
        input  tick, sensor, preempt, preempt_id,
        output led, green_id, phase
    );
`else
    modport master (
        output tick, sensor,
        input  led, green_id, phase
    );

    modport slave (
        input  tick, sensor,
        output led, green_id, phase
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the next request strictly after 'last', wrapping to 'last' itself.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
//
// Ports:
//   req         - request vector
//   last        - index of the previous owner; search starts at last+1
//   grant_id    - chosen index (0 when nothing is requested)
//   grant_valid - at least one request is set
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid
);

    // hi_*: lowest requester above 'last'; lo_*: lowest requester overall,
    // which is the wrapped-around choice when nothing sits above 'last'.
    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic            lo_found;
    logic [ID_W-1:0] lo_id;

    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        // Descending scan so the final hit recorded is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (i > int'(last)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        grant_valid = lo_found;
        grant_id    = hi_found ? hi_id : lo_id;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic phase controller: latched requests, round-robin grants, tick-timed phases.
// Latency: led/green_id/phase change one clk after the deciding tick; sensor latched next clk.
// Backpressure: none; requests stay latched until their approach is served.
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all lamps red, requests cleared)
//   tif   - slave side of traffic_phase_ctrl_if (tick, sensor in; led, green_id, phase out)
// Build option: TRAFFIC_PREEMPT_EN adds preempt/preempt_id handling (emergency preemption).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 60,
    parameter int YELLOW_T   = 3,
    parameter int ALL_RED_T  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_ctrl_if.slave  tif
);

    localparam int ID_W  = $clog2(N_APPROACH);
    localparam int LED_W = 3 * N_APPROACH;

    // A phase of D ticks ends on the tick seen while the timer holds D-1.
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);

    phase_e                  state_q;
    logic [CNT_W-1:0]        timer_q;
    logic [ID_W-1:0]         green_id_q;
    logic [LED_W-1:0]        led_q;
    logic [N_APPROACH-1:0]   req_q;
    logic [N_APPROACH-1:0]   req_d;

    logic [CNT_W-1:0]        timer_inc;
    logic [N_APPROACH-1:0]   owner_mask;
    logic                    other_req;
    logic                    leave_norm;
    logic                    leave_green;
    logic                    ar_done;
    logic                    yel_done;
    logic [ID_W-1:0]         arb_id;
    logic                    arb_valid;
    logic [ID_W-1:0]         next_id;

    function automatic logic [LED_W-1:0] led_vec(input logic [ID_W-1:0] id,
                                                 input logic [2:0]      lamp);
        logic [LED_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            v[3*i +: 3] = (id == ID_W'(i)) ? lamp : LED_RED;
        end
        return v;
    endfunction

    rr_arbiter #(
        .N (N_APPROACH)
    ) u_arb (
        .req         (req_q),
        .last        (green_id_q),
        .grant_id    (arb_id),
        .grant_valid (arb_valid)
    );

    // Home green can sit for a very long time; saturate instead of wrapping
    // so the GREEN_MIN comparison stays true.
    assign timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + 1'b1;
    assign ar_done   = tif.tick && (timer_q == AR_LAST);
    assign yel_done  = tif.tick && (timer_q == Y_LAST);

    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            owner_mask[i] = (green_id_q == ID_W'(i));
        end
    end

    // The owner's own latch may still read set in its first green cycle, so
    // it is masked out of the "someone else is waiting" test.
    assign other_req = |(req_q & ~owner_mask);

    // Home approach only yields to traffic; others also time out at GREEN_MAX.
    // '>=' on GREEN_MAX lets an over-long green (after preemption) leave at once.
    assign leave_norm = tif.tick &&
                        (((timer_q >= GMIN_LAST) && other_req) ||
                         ((green_id_q != '0) && (timer_q >= GMAX_LAST)));

`ifdef TRAFFIC_PREEMPT_EN
    logic preempt_hold;

    assign preempt_hold = tif.preempt && (tif.preempt_id == green_id_q);
    // Preemption cuts a foreign green on the next clk without waiting for a tick.
    assign leave_green  = tif.preempt ? !preempt_hold : leave_norm;
    assign next_id      = tif.preempt ? tif.preempt_id : (arb_valid ? arb_id : '0);
`else
    assign leave_green  = leave_norm;
    assign next_id      = arb_valid ? arb_id : '0;
`endif

    // Request latches: set by sensor, held clear for the approach that is green.
    always_comb begin
        req_d = req_q | tif.sensor;
        if (state_q == GREEN) begin
            req_d = req_d & ~owner_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    // Phase FSM with registered lamp, owner and phase outputs. green_id keeps
    // the last owner through yellow and all-red: it is the arbitration origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALL_RED;
            timer_q    <= '0;
            green_id_q <= '0;
            led_q      <= {N_APPROACH{LED_RED}};
        end else begin
            if (tif.tick) begin
                timer_q <= timer_inc;
            end
            case (state_q)
                ALL_RED: begin
                    if (ar_done) begin
                        state_q    <= GREEN;
                        timer_q    <= '0;
                        green_id_q <= next_id;
                        led_q      <= led_vec(next_id, LED_GREEN);
                    end
                end
                GREEN: begin
                    if (leave_green) begin
                        state_q <= YELLOW;
                        timer_q <= '0;
                        led_q   <= led_vec(green_id_q, LED_YELLOW);
                    end
                end
                YELLOW: begin
                    if (yel_done) begin
                        state_q <= ALL_RED;
                        timer_q <= '0;
                        led_q   <= {N_APPROACH{LED_RED}};
                    end
                end
                default: begin
                    state_q <= ALL_RED;
                    timer_q <= '0;
                    led_q   <= {N_APPROACH{LED_RED}};
                end
            endcase
        end
    end

    assign tif.led      = led_q;
    assign tif.green_id = green_id_q;
    assign tif.phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: segment table plus hand-written corner sequences.
// Latency: expected output changes are queued with the cycle they must appear on.
// Backpressure: none; tick is held high so every clk is one tick.
module tb_traffic_phase_ctrl;

    localparam int N = 4;
    localparam logic [11:0] ALLRED = 12'b001_001_001_001;

    typedef struct {
        int         stamp;
        logic [1:0] ph;
        logic [1:0] gid;
        logic [11:0] led;
    } ev_t;

    // One green segment: a sensor pulse applied 'offset' cycles into the green
    // of 'owner', the expected green length, and the next owner.
    typedef struct {
        logic [3:0] pulse;
        int         offset;
        int         owner;
        int         len;
        int         next_id;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic [1:0]  prev_ph;
    logic [1:0]  prev_gid;
    logic [11:0] prev_led;

    traffic_phase_ctrl_if #(.N_APPROACH(N)) tif();

    traffic_phase_ctrl #(
        .N_APPROACH (N),
        .CNT_W      (8),
        .GREEN_MIN  (10),
        .GREEN_MAX  (60),
        .YELLOW_T   (3),
        .ALL_RED_T  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [11:0] lamps(input int owner, input logic [2:0] lamp);
        logic [11:0] v;
        for (int i = 0; i < N; i++) v[3*i +: 3] = (i == owner) ? lamp : 3'b001;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int stamp, input logic [1:0] ph, input int gid, input logic [11:0] led);
        ev_t e;
        e.stamp = stamp;
        e.ph    = ph;
        e.gid   = 2'(gid);
        e.led   = led;
        exp_q.push_back(e);
    endtask

    // Green of 'owner' started at g and lasts len: yellow, all-red, next green.
    task automatic push_cycle(input int g, input int owner, input int len, input int nxt);
        push_ev(g + len,     2'd2, owner, lamps(owner, 3'b010));
        push_ev(g + len + 3, 2'd0, owner, ALLRED);
        push_ev(g + len + 5, 2'd1, nxt,   lamps(nxt, 3'b100));
    endtask

    task automatic monitor();
        int  nonred;
        ev_t e;
        if (!rst_n) begin
            prev_ph  = 2'd0;
            prev_gid = 2'd0;
            prev_led = ALLRED;
            return;
        end
        nonred = 0;
        for (int i = 0; i < N; i++) if (tif.led[3*i +: 3] != 3'b001) nonred++;
        chk("at_most_one_non_red", 32'(nonred <= 1), 32'd1);
        if (tif.phase != prev_ph || tif.green_id != prev_gid || tif.led != prev_led) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: cyc %0d phase %0d id %0d led %b, expected no change",
                         cyc, tif.phase, tif.green_id, tif.led);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.stamp);
                chk("event_phase", tif.phase, e.ph);
                chk("event_id",    tif.green_id, e.gid);
                chk("event_led",   tif.led, e.led);
            end
            prev_ph  = tif.phase;
            prev_gid = tif.green_id;
            prev_led = tif.led;
        end else if (exp_q.size() != 0 && exp_q[0].stamp <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event: got no change by cyc %0d, expected phase %0d id %0d at cyc %0d",
                     cyc, e.ph, e.gid, e.stamp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_cyc(input int s);
        while (cyc < s) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_t segs[8];
        int   g;
        int   p;

        segs[0] = '{4'b0100,  3, 0, 10, 2};  // sensor[2] at tick 3 -> leave at GREEN_MIN
        segs[1] = '{4'b0000,  0, 2, 60, 0};  // lone non-home green times out, back home
        segs[2] = '{4'b0100, 12, 0, 14, 2};  // late request: home leaves on next tick
        segs[3] = '{4'b1010,  2, 2, 10, 3};  // requests 1,3 with owner 2 -> 3 first
        segs[4] = '{4'b0000,  0, 3, 10, 1};  // ... then 1
        segs[5] = '{4'b1000, 64, 1, 60, 0};  // request on the decision edge is not seen
        segs[6] = '{4'b0000,  0, 0, 10, 3};  // that request served on the next round
        segs[7] = '{4'b1000,  4, 3, 60, 0};  // own sensor while green is ignored

        rst_n      = 1'b0;
        tif.tick   = 1'b1;
        tif.sensor = '0;
`ifdef TRAFFIC_PREEMPT_EN
        tif.preempt    = 1'b0;
        tif.preempt_id = '0;
`endif
        step();
        step();
        chk("reset_led",   tif.led, ALLRED);
        chk("reset_phase", tif.phase, 2'd0);
        chk("reset_id",    tif.green_id, 2'd0);

        rst_n = 1'b1;
        push_ev(2, 2'd1, 0, lamps(0, 3'b100));
        step();
        chk("all_red_after_release", tif.led, ALLRED);
        g = 2;
        wait_cyc(g);

        for (int s = 0; s < 8; s++) begin
            chk("segment_owner", tif.green_id, segs[s].owner);
            chk("segment_phase", tif.phase, 2'd1);
            push_cycle(g, segs[s].owner, segs[s].len, segs[s].next_id);
            if (segs[s].pulse != 4'b0000) begin
                wait_cyc(g + segs[s].offset);
                tif.sensor = segs[s].pulse;
                step();
                tif.sensor = '0;
            end
            g = g + segs[s].len + 5;
            wait_cyc(g);
        end

        // Home green with nothing pending holds well past GREEN_MAX.
        wait_cyc(g + 80);
        chk("home_hold_phase", tif.phase, 2'd1);
        chk("home_hold_id",    tif.green_id, 2'd0);

        // Request approach 1, then reset in the middle of the yellow.
        push_ev(g + 82, 2'd2, 0, lamps(0, 3'b010));
        tif.sensor = 4'b0010;
        step();
        tif.sensor = '0;
        wait_cyc(g + 83);
        chk("mid_yellow_phase", tif.phase, 2'd2);
        rst_n = 1'b0;
        step();
        chk("reset_mid_yellow_led",   tif.led, ALLRED);
        chk("reset_mid_yellow_phase", tif.phase, 2'd0);
        chk("reset_mid_yellow_id",    tif.green_id, 2'd0);
        step();
        rst_n = 1'b1;
        push_ev(2, 2'd1, 0, lamps(0, 3'b100));
        wait_cyc(32);
        chk("req_cleared_phase", tif.phase, 2'd1);
        chk("req_cleared_id",    tif.green_id, 2'd0);

`ifdef TRAFFIC_PREEMPT_EN
        // Preempt to 3 from home green: yellow next clk, then 3 held past GREEN_MAX.
        p = 34;
        wait_cyc(p);
        tif.preempt    = 1'b1;
        tif.preempt_id = 2'd3;
        push_ev(p + 1, 2'd2, 0, lamps(0, 3'b010));
        push_ev(p + 4, 2'd0, 0, ALLRED);
        push_ev(p + 6, 2'd1, 3, lamps(3, 3'b100));
        wait_cyc(p + 76);
        chk("preempt_hold_id",    tif.green_id, 2'd3);
        chk("preempt_hold_phase", tif.phase, 2'd1);
        tif.preempt = 1'b0;
        push_ev(p + 77, 2'd2, 3, lamps(3, 3'b010));
        push_ev(p + 80, 2'd0, 3, ALLRED);
        push_ev(p + 82, 2'd1, 0, lamps(0, 3'b100));
        wait_cyc(p + 100);
`else
        p = 32;
        wait_cyc(p + 20);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
